// File: rtl/reg_wb_ctrl_if.sv
// Writeback bus between the result producers (LSU, ALU), the register file
// write port and the operand bypass lookup.
interface reg_wb_ctrl_if;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic        busy;

  modport master (
    output lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data,
           fwd_raddr1, fwd_raddr2,
    input  lsu_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, busy
  );

  modport slave (
    input  lsu_valid, lsu_rd, lsu_data, alu_valid, alu_rd, alu_data,
           fwd_raddr1, fwd_raddr2,
    output lsu_ready, alu_ready, rf_we, rf_waddr, rf_wdata,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, busy
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Writeback queue: merges LSU and ALU results into one register-file write
// port in acceptance order, with a combinational bypass of pending writes.
module reg_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_wb_ctrl_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [4:0]  q_rd   [DEPTH];
  logic [31:0] q_data [DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  cnt_t        count;
  cnt_t        space;
  ptr_t        alu_slot;
  logic        lsu_push;
  logic        alu_push;
  logic        pop;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  // Readiness depends only on the registered count, so a same-edge pop never
  // frees space for a producer.
  assign space         = cnt_t'(DEPTH) - count;
  assign bus.lsu_ready = (space >= cnt_t'(1));
  assign bus.alu_ready = (space >= cnt_t'(2)) || ((space >= cnt_t'(1)) && !bus.lsu_valid);

  // Writes to x0 are accepted but dropped here.
  assign lsu_push = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
  assign pop      = (count != cnt_t'(0));
  assign alu_slot = wr_ptr + ptr_t'(lsu_push);

  // Queue storage; LSU takes the tail slot first, ALU the one after it.
  always_ff @(posedge clk) begin
    if (lsu_push) begin
      q_rd[wr_ptr]   <= bus.lsu_rd;
      q_data[wr_ptr] <= bus.lsu_data;
    end
    if (alu_push) begin
      q_rd[alu_slot]   <= bus.alu_rd;
      q_data[alu_slot] <= bus.alu_data;
    end
  end

  // Pointer and occupancy bookkeeping: up to two pushes and one pop per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ptr_t'(lsu_push) + ptr_t'(alu_push);
      rd_ptr <= rd_ptr + ptr_t'(pop);
      count  <= count + cnt_t'(lsu_push) + cnt_t'(alu_push) - cnt_t'(pop);
    end
  end

  // Register-file output stage: head of queue moves out every non-empty edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (pop) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= q_rd[rd_ptr];
      rf_wdata_q <= q_data[rd_ptr];
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = pop || rf_we_q;

  // Bypass search from oldest (output stage) to youngest queue entry, so the
  // last match seen is the newest pending value for that register.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] addr);
    logic        hit;
    logic [31:0] data;
    ptr_t        idx;
    hit  = 1'b0;
    data = '0;
    if (addr != 5'd0) begin
      if (rf_we_q && (rf_waddr_q == addr)) begin
        hit  = 1'b1;
        data = rf_wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + ptr_t'(i);
        if ((cnt_t'(i) < count) && (q_rd[idx] == addr)) begin
          hit  = 1'b1;
          data = q_data[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  assign {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.fwd_raddr1);
  assign {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.fwd_raddr2);
endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of writeback queue entries (power of two, 2..16).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have lsu_valid/lsu_rd/lsu_data  input  1/5/32  load-unit result request, destination register and value.
REQ-005 SHALL have lsu_ready  output  1  load-unit result accepted this cycle when lsu_valid is also high.
REQ-006 SHALL have alu_valid/alu_rd/alu_data  input  1/5/32  ALU result request, destination register and value.
REQ-007 SHALL have alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-008 SHALL have rf_we/rf_waddr/rf_wdata  output  1/5/32  register-file write port (registered outputs).
REQ-009 SHALL have fwd_raddr1/fwd_raddr2  input  5/5  operand addresses being read from the register file.
REQ-010 SHALL have fwd_hit1/fwd_data1, fwd_hit2/fwd_data2  output  1/32 each  pending-write bypass result per read address.
REQ-011 SHALL have busy  output  1  high while the queue or the rf output stage holds an entry.

Function
REQ-012 SHALL hold up to DEPTH entries {rd, data} in a FIFO; pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-013 SHALL compute ready from registered count only: space = DEPTH-count; lsu_ready = (space>=1); alu_ready = (space>=2) or (space>=1 and !lsu_valid).
REQ-014 SHALL accept a request on an edge where valid and ready are both high; LSU has fixed priority and is enqueued before ALU when both are accepted.
REQ-015 SHALL accept but discard (not enqueue, no rf write) any request with rd == 0.
REQ-016 SHALL pop the head on every edge where count > 0 and load it into rf_waddr/rf_wdata with rf_we = 1; on edges with count == 0, SHALL set rf_we = 0.
REQ-017 Latency: an entry accepted into an empty queue at edge N SHALL appear on rf_we/rf_waddr/rf_wdata after edge N+1 (written by the regfile at edge N+2).
REQ-018 SHALL update count for up to two enqueues and one dequeue on the same edge; full (count == DEPTH) blocks both producers even if a pop occurs that edge.
REQ-019 SHALL preserve acceptance order for all rf writes; no accepted nonzero-rd entry may be lost or duplicated.
REQ-020 Forwarding SHALL be combinational: search the rf output stage (when rf_we = 1) plus all valid queue entries for rd == fwd_raddrN; the youngest match wins; fwd_dataN = 0 on miss.
REQ-021 fwd_hitN SHALL be 0 whenever fwd_raddrN == 0.
REQ-022 busy SHALL equal (count != 0) or rf_we.

Reset
REQ-023 While rst_n == 0, SHALL immediately force rf_we = 0, rf_waddr = 0, rf_wdata = 0, count = 0, and both pointers = 0, independent of clk.
REQ-024 Reset mid-operation SHALL discard all pending entries; no rf write of pre-reset data SHALL occur after release.
REQ-025 After reset, lsu_ready = alu_ready = 1, busy = 0, fwd_hit1 = fwd_hit2 = 0.

Verification
REQ-026 ALU x5 = 123 accepted at edge N into an empty queue -> rf_we = 1, rf_waddr = 5, rf_wdata = 123 after edge N+1 for exactly one cycle; regfile read of x5 returns 123.
REQ-027 ALU x0 = 999 accepted -> rf_we stays 0, busy stays 0; fwd_raddr1 = 0 gives fwd_hit1 = 0.
REQ-028 LSU x3 = 7 and ALU x4 = 9 both valid on the same edge into an empty queue -> both accepted; rf writes x3 = 7, then x4 = 9 on consecutive cycles.
REQ-029 DEPTH = 4, both producers valid every cycle with nonzero rd -> alu_ready drops to 0 once count >= 3; the rf write sequence matches the acceptance order exactly, with no loss.
REQ-030 Enqueue x7 = 0xAA, then x7 = 0xBB (both pending), fwd_raddr1 = 7 -> fwd_hit1 = 1, fwd_data1 = 0xBB; after both drain, fwd_hit1 = 0.
REQ-031 Three entries queued, rst_n pulsed low between edges -> rf_we = 0 and busy = 0 immediately; no rf_we pulses after release until a new request is accepted.
